// File: rtl/lcd_bus_decoder.sv
// Receive side of an HD44780-style 8-bit LCD write bus: decodes command/data strobes
// into a 2x16 shadow character buffer plus cursor, entry-mode and display state.
module lcd_bus_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_E_HIGH  = 4,
  parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs,
  input  logic       e,
  input  logic [7:0] data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic       char_valid,
  output logic [7:0] last_byte,
  output logic       overrun,
  output logic       addr_err
);

  localparam int unsigned HW = $clog2(MIN_E_HIGH + 1);
  localparam logic [HW-1:0] HI_MAX = HW'(MIN_E_HIGH);

  typedef enum logic [1:0] {IDLE, DECODE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [9:0]  sync_q [SYNC_STAGES];
  logic        rs_s, e_s, e_d;
  logic [7:0]  data_s;
  logic [HW-1:0] hi_cnt;
  logic        strobe;
  logic        cap_rs;
  logic [7:0]  cap_data;
  logic [4:0]  clr_idx, clr_d, cursor_d;
  logic        inc_mode, inc_d, disp_d, aerr_d;
  logic        we;
  logic [4:0]  waddr;
  logic [7:0]  wdata;
  logic [7:0]  mem [32];

  // rs, e and data share one pipeline so they stay cycle-aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {rs, e, data};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {rs_s, e_s, data_s} = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt <= '0;
      e_d    <= 1'b0;
    end else begin
      e_d <= e_s;
      if (!e_s)                hi_cnt <= '0;
      else if (hi_cnt != HI_MAX) hi_cnt <= hi_cnt + 1'b1;
    end
  end

  assign strobe = e_d && !e_s && (hi_cnt == HI_MAX);

  // The clear command blanks index 0 in its decode cycle, so busy spans exactly 32 cycles
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_idx;
    cursor_d   = cursor;
    inc_d      = inc_mode;
    disp_d     = display_on;
    aerr_d     = addr_err;
    we         = 1'b0;
    waddr      = clr_idx;
    wdata      = BLANK_CHAR;
    busy       = 1'b0;
    cmd_valid  = 1'b0;
    char_valid = 1'b0;
    case (state_q)
      IDLE: if (strobe) state_d = DECODE;
      DECODE: begin
        state_d = IDLE;
        if (cap_rs) begin
          char_valid = 1'b1;
          we         = 1'b1;
          waddr      = cursor;
          wdata      = cap_data;
          cursor_d   = inc_mode ? cursor + 5'd1 : cursor - 5'd1;
        end else begin
          cmd_valid = 1'b1;
          if (cap_data[7]) begin
            if (cap_data[6:4] == 3'b000)      cursor_d = {1'b0, cap_data[3:0]};
            else if (cap_data[6:4] == 3'b100) cursor_d = {1'b1, cap_data[3:0]};
            else                              aerr_d   = 1'b1;
          end else if (cap_data[6:4] != 3'b000) begin
            cursor_d = cursor;
          end else if (cap_data[3]) begin
            disp_d = cap_data[2];
          end else if (cap_data[2]) begin
            inc_d = cap_data[1];
          end else if (cap_data[1]) begin
            cursor_d = '0;
          end else if (cap_data[0]) begin
            cursor_d = '0;
            busy     = 1'b1;
            we       = 1'b1;
            waddr    = '0;
            clr_d    = 5'd1;
            state_d  = CLEAR;
          end
        end
      end
      CLEAR: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = clr_idx;
        clr_d = clr_idx + 5'd1;
        if (clr_idx == 5'd31) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_idx    <= '0;
      cursor     <= '0;
      inc_mode   <= 1'b1;
      display_on <= 1'b0;
      addr_err   <= 1'b0;
      overrun    <= 1'b0;
      cap_rs     <= 1'b0;
      cap_data   <= '0;
      last_byte  <= '0;
      rd_data    <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx    <= clr_d;
      cursor     <= cursor_d;
      inc_mode   <= inc_d;
      display_on <= disp_d;
      addr_err   <= aerr_d;
      rd_data    <= mem[rd_addr];
      if (strobe && state_q != IDLE) overrun <= 1'b1;
      if (strobe && state_q == IDLE) begin
        cap_rs   <= rs_s;
        cap_data <= data_s;
      end
      if (state_q == DECODE) last_byte <= cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Scoreboard bench for lcd_bus_decoder: directed scenarios plus randomized bus traffic
// checked against an arithmetic model of the LCD command set.
module tb_lcd_bus_decoder;
  logic       clk = 1'b0, rst = 1'b0, rs = 1'b0, e = 1'b0;
  logic [7:0] data = '0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data, last_byte;
  logic [4:0] cursor;
  logic       display_on, busy, cmd_valid, char_valid, overrun, addr_err;

  lcd_bus_decoder #(.SYNC_STAGES(2), .MIN_E_HIGH(4), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .rs(rs), .e(e), .data(data), .rd_addr(rd_addr),
    .rd_data(rd_data), .cursor(cursor), .display_on(display_on), .busy(busy),
    .cmd_valid(cmd_valid), .char_valid(char_valid), .last_byte(last_byte),
    .overrun(overrun), .addr_err(addr_err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_char;
    logic [7:0] b;
    logic [4:0] cur;
    logic       disp;
    logic       aerr;
  } exp_t;

  exp_t       q[$];
  int         total = 0, bad = 0;
  logic [7:0] mbuf [32];
  int         mcur, clears_exp = 0, runs_seen = 0, run = 0;
  bit         minc, mdisp, maerr, movr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mcur = 0; minc = 1; mdisp = 0; maerr = 0; movr = 0;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
  endfunction

  function automatic void apply(input logic r, input logic [7:0] b);
    exp_t x;
    int a;
    if (r) begin
      mbuf[mcur] = b;
      mcur = minc ? (mcur + 1) % 32 : (mcur + 31) % 32;
    end else if (b >= 8'h80) begin
      a = int'(b) - 128;
      if (a < 16) mcur = a;
      else if (a >= 'h40 && a < 'h50) mcur = 16 + a - 'h40;
      else maerr = 1;
    end else if (b >= 8'h08 && b < 8'h10) begin
      mdisp = b[2];
    end else if (b >= 8'h04 && b < 8'h08) begin
      minc = b[1];
    end else if (b == 8'h02 || b == 8'h03) begin
      mcur = 0;
    end else if (b == 8'h01) begin
      mcur = 0;
      for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
      clears_exp++;
    end
    x.is_char = r; x.b = b; x.cur = 5'(mcur); x.disp = mdisp; x.aerr = maerr;
    q.push_back(x);
  endfunction

  // Pulse monitor: every valid pulse must match the next queued expectation
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (!rst && (cmd_valid || char_valid)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {cmd_valid, char_valid}, 0);
      end else begin
        x = q.pop_front();
        check("pulse_kind", {cmd_valid, char_valid}, {!x.is_char, x.is_char});
        @(negedge clk);
        check("pulse_width", cmd_valid | char_valid, 0);
        check("last_byte", last_byte, x.b);
        check("cursor", cursor, x.cur);
        check("display_on", display_on, x.disp);
        check("addr_err", addr_err, x.aerr);
      end
    end
  end

  // Every completed busy run must last 32 cycles; runs cut by reset are discarded
  always @(negedge clk) begin
    if (rst) run = 0;
    else if (busy) run++;
    else if (run != 0) begin
      check("busy_len", run, 32);
      runs_seen++;
      run = 0;
    end
  end

  task automatic strobe(input logic r, input logic [7:0] b, input bit dropped);
    if (dropped) movr = 1;
    else apply(r, b);
    @(negedge clk);
    rs = r; data = b; e = 1'b1;
    repeat (6) @(negedge clk);
    e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic short_pulse(input int k);
    @(negedge clk);
    rs = 1'b1; data = 8'h77; e = 1'b1;
    repeat (k) @(negedge clk);
    e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      @(negedge clk);
      check($sformatf("rd_data[%0d]", i), rd_data, mbuf[i]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_cursor", cursor, 0);
    check("rst_valids", {cmd_valid, char_valid}, 0);
    check("rst_last_byte", last_byte, 0);
    check("rst_flags", {overrun, addr_err, display_on}, 0);
    check("rst_rd_data", rd_data, 0);
    model_reset();
    clears_exp++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_after_clear", busy, 0);
  endtask

  initial begin
    int op;
    logic [7:0] b;
    model_reset();
    #1 rst = 1'b1;
    do_reset();
    read_all();

    strobe(0, 8'h80, 0); strobe(1, 8'h41, 0); strobe(1, 8'h42, 0);
    strobe(0, 8'hC0, 0);
    for (int i = 0; i < 17; i++) strobe(1, 8'(8'h30 + i), 0);
    read_all();

    strobe(0, 8'h04, 0); strobe(0, 8'h80, 0); strobe(1, 8'h5A, 0);
    strobe(0, 8'h0C, 0); strobe(0, 8'h08, 0);
    read_all();

    strobe(0, 8'h01, 0);
    strobe(1, 8'h55, 1);
    check("overrun", overrun, movr);
    repeat (40) @(negedge clk);
    read_all();

    short_pulse(2);
    short_pulse(3);
    check("short_cursor", cursor, mcur);
    strobe(0, 8'h95, 0);
    strobe(1, 8'h11, 0);

    strobe(0, 8'h01, 0);
    clears_exp--;
    repeat (10) @(negedge clk);
    do_reset();
    read_all();

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) strobe(1, 8'($urandom), 0);
      else if (op == 5) short_pulse($urandom_range(1, 3));
      else if (op == 6) strobe(0, 8'(8'h80 | 8'($urandom_range(0, 127))), 0);
      else if (op == 7) strobe(0, 8'($urandom_range(2, 15)), 0);
      else if (op == 8) begin
        b = 8'($urandom_range(0, 127));
        if (b == 8'h01) b = 8'h00;
        strobe(0, b, 0);
      end else if ($urandom_range(0, 2) == 0) begin
        strobe(0, 8'h01, 0);
        repeat (40) @(negedge clk);
      end else strobe(1, 8'($urandom), 0);
      if (it % 20 == 19) read_all();
    end

    repeat (10) @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("busy_runs", runs_seen, clears_exp);
    check("final_overrun", overrun, movr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
